// File: rtl/usart_pkg.sv
// Shared USART definitions: default character size, parity encodings,
// serial line levels and the parity helper used by the TX datapath.
package usart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int MAX_DATA_WIDTH     = 9;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Unused upper bits of the argument are zero, so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input parity_mode_e              mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/tx_udr_buffer.sv
// UDR transmit buffer: holds the character written by the CPU until the
// shift register takes it, and flags writes that overwrite an unsent character.
module tx_udr_buffer
  import usart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  txclk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  load,
  output logic [DATA_WIDTH-1:0] udr_data,
  output logic                  full,
  output logic                  wr_collision
);

  // Capture every write; the previous contents go to the shift register on a same-cycle load.
  always_ff @(posedge txclk or negedge rst_n) begin
    if (!rst_n) begin
      udr_data <= '0;
    end else if (wr) begin
      udr_data <= wr_data;
    end
  end

  // A write always leaves the buffer full; a load without a write empties it.
  always_ff @(posedge txclk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (wr) begin
      full <= 1'b1;
    end else if (load) begin
      full <= 1'b0;
    end
  end

  // One-cycle pulse when a write lands on a character that is not being loaded away.
  always_ff @(posedge txclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_collision <= 1'b0;
    end else begin
      wr_collision <= wr & full & ~load;
    end
  end

endmodule

// File: rtl/tx_datapath.sv
// USART transmit datapath: UDR buffer, shift register, bit counter, parity
// bit and the serial line mux, all sequenced by the upstream TX control FSM.
module tx_datapath
  import usart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  i_txclk,
  input  logic                  i_rst_n,
  input  logic                  i_udr_wr,
  input  logic [DATA_WIDTH-1:0] i_udr_data,
  input  logic                  i_upm0,
  input  logic                  i_start_bit_insert,
  input  logic                  i_parity_generate,
  input  logic                  i_reg_wr_or_shift,
  input  logic                  i_rewr_or_count,
  input  logic                  i_data_transmit,
  input  logic                  i_parity_insert,
  input  logic                  i_stop_bit,
  output logic                  o_txd,
  output logic                  o_data_in_udr,
  output logic                  o_last_bit_sent,
  output logic                  o_udre,
  output logic                  o_wr_collision
);

  logic                  load;
  logic [DATA_WIDTH-1:0] udr_data;
  logic                  udr_full;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  parity_bit;

  assign load = i_reg_wr_or_shift & i_rewr_or_count;

  tx_udr_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_udr_buffer (
    .txclk        (i_txclk),
    .rst_n        (i_rst_n),
    .wr           (i_udr_wr),
    .wr_data      (i_udr_data),
    .load         (load),
    .udr_data     (udr_data),
    .full         (udr_full),
    .wr_collision (o_wr_collision)
  );

  assign o_data_in_udr   = udr_full;
  assign o_udre          = ~udr_full;
  assign o_last_bit_sent = i_data_transmit & (bit_cnt == '0);

  // Shift register loads from UDR at START, then shifts right with zero fill each data cycle.
  always_ff @(posedge i_txclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= udr_data;
    end else if (i_data_transmit) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  // Bit counter restarts at the top on load and counts down to zero, where it holds.
  always_ff @(posedge i_txclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt <= '0;
    end else if (load) begin
      bit_cnt <= CNT_W'(DATA_WIDTH - 1);
    end else if (i_data_transmit && (bit_cnt != '0)) begin
      bit_cnt <= bit_cnt - CNT_W'(1);
    end
  end

  // Parity is computed from the character as it moves into the shift register.
  always_ff @(posedge i_txclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      parity_bit <= 1'b0;
    end else if (load && i_parity_generate) begin
      parity_bit <= calc_parity(MAX_DATA_WIDTH'(udr_data), parity_mode_e'(i_upm0));
    end
  end

  // Line mux: start beats data beats parity; stop, idle and anything undefined drive high.
  always_comb begin
    o_txd = IDLE_LEVEL;
    if (i_start_bit_insert) begin
      o_txd = START_LEVEL;
    end else if (i_data_transmit) begin
      o_txd = shift_reg[0];
    end else if (i_parity_insert) begin
      o_txd = parity_bit;
    end else if (i_stop_bit) begin
      o_txd = IDLE_LEVEL;
    end
  end

endmodule

// File: tb/tb_tx_datapath.sv
// Directed bench for tx_datapath: plays the TX FSM role, sends table-driven
// frames and a few hand-written multi-cycle sequences, and checks the line.
module tb_tx_datapath;
  import usart_pkg::*;

  localparam int DW = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          txclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          udr_wr = 1'b0;
  logic [DW-1:0] udr_data = '0;
  logic          upm0 = 1'b0;
  logic          start_bit_insert = 1'b0;
  logic          parity_generate = 1'b0;
  logic          reg_wr_or_shift = 1'b0;
  logic          rewr_or_count = 1'b0;
  logic          data_transmit = 1'b0;
  logic          parity_insert = 1'b0;
  logic          stop_bit = 1'b0;
  logic          txd;
  logic          data_in_udr;
  logic          last_bit_sent;
  logic          udre;
  logic          wr_collision;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       upm;
    logic       par_en;
    logic       exp_par;
  } vec_t;

  vec_t vecs[8];

  tx_datapath #(.DATA_WIDTH(DW)) dut (
    .i_txclk            (txclk),
    .i_rst_n            (rst_n),
    .i_udr_wr           (udr_wr),
    .i_udr_data         (udr_data),
    .i_upm0             (upm0),
    .i_start_bit_insert (start_bit_insert),
    .i_parity_generate  (parity_generate),
    .i_reg_wr_or_shift  (reg_wr_or_shift),
    .i_rewr_or_count    (rewr_or_count),
    .i_data_transmit    (data_transmit),
    .i_parity_insert    (parity_insert),
    .i_stop_bit         (stop_bit),
    .o_txd              (txd),
    .o_data_in_udr      (data_in_udr),
    .o_last_bit_sent    (last_bit_sent),
    .o_udre             (udre),
    .o_wr_collision     (wr_collision)
  );

  always #5 txclk = ~txclk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit reached", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic dt, input logic pins,
                               input logic stop, input logic pgen, input logic ld,
                               input logic wr, input logic [7:0] wdata);
    start_bit_insert = st;
    data_transmit    = dt;
    parity_insert    = pins;
    stop_bit         = stop;
    parity_generate  = pgen;
    reg_wr_or_shift  = ld;
    rewr_or_count    = ld;
    udr_wr           = wr;
    udr_data         = wdata;
  endtask

  task automatic nextCycle();
    @(posedge txclk);
    #1;
  endtask

  task automatic writeIdle(input logic [7:0] d);
    applyStimulus(L, L, L, H, L, L, H, d);
    @(negedge txclk);
    checkOutput("idle_write txd", txd, H);
    nextCycle();
  endtask

  // Drives one whole frame; optional UDR write at frame cycle wr_cycle (-1 for none).
  task automatic runFrame(input string tag, input logic [7:0] exp_data, input logic upm,
                          input logic par_en, input logic exp_par,
                          input int wr_cycle, input logic [7:0] wr_data);
    logic [10:0] exp_line;
    logic        exp_full;
    logic        wr;
    int          ncyc;
    exp_line = par_en ? {H, exp_par, exp_data, L} : {L, H, exp_data, L};
    ncyc     = par_en ? 11 : 10;
    upm0     = upm;
    for (int c = 0; c < ncyc; c++) begin
      wr = (c == wr_cycle);
      if (c == 0)
        applyStimulus(H, L, L, L, par_en, H, wr, wr_data);
      else if (c <= 8)
        applyStimulus(L, H, (c == 8) && par_en, L, L, L, wr, wr_data);
      else if (par_en && c == 9)
        applyStimulus(L, L, H, L, L, L, wr, wr_data);
      else
        applyStimulus(L, L, L, H, L, L, wr, wr_data);
      exp_full = (c == 0) ? H : ((wr_cycle >= 0) && (c > wr_cycle));
      @(negedge txclk);
      checkOutput($sformatf("%s txd c%0d", tag, c), txd, exp_line[c]);
      checkOutput($sformatf("%s last c%0d", tag, c), last_bit_sent, c == 8);
      checkOutput($sformatf("%s full c%0d", tag, c), data_in_udr, exp_full);
      checkOutput($sformatf("%s udre c%0d", tag, c), udre, ~exp_full);
      checkOutput($sformatf("%s coll c%0d", tag, c), wr_collision, L);
      nextCycle();
    end
  endtask

  initial begin
    vecs[0] = '{"a5_even", 8'hA5, PAR_EVEN, H, L};
    vecs[1] = '{"03_odd",  8'h03, PAR_ODD,  H, H};
    vecs[2] = '{"01_odd",  8'h01, PAR_ODD,  H, L};
    vecs[3] = '{"00_odd",  8'h00, PAR_ODD,  H, H};
    vecs[4] = '{"ff_even", 8'hFF, PAR_EVEN, H, L};
    vecs[5] = '{"80_even", 8'h80, PAR_EVEN, H, H};
    vecs[6] = '{"3c_nopar", 8'h3C, PAR_EVEN, L, L};
    vecs[7] = '{"c6_odd",  8'hC6, PAR_ODD,  H, H};

    #1;
    checkOutput("reset txd", txd, H);
    checkOutput("reset udre", udre, H);
    checkOutput("reset full", data_in_udr, L);
    checkOutput("reset last", last_bit_sent, L);
    checkOutput("reset coll", wr_collision, L);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(L, L, L, H, L, L, L, 8'h00);
    nextCycle();

    for (int i = 0; i < 8; i++) begin
      writeIdle(vecs[i].data);
      runFrame(vecs[i].name, vecs[i].data, vecs[i].upm, vecs[i].par_en, vecs[i].exp_par, -1, 8'h00);
    end

    writeIdle(8'h55);
    runFrame("b2b_55", 8'h55, PAR_EVEN, H, L, 3, 8'h0F);
    runFrame("b2b_0f", 8'h0F, PAR_EVEN, H, L, -1, 8'h00);

    writeIdle(8'h11);
    applyStimulus(L, L, L, H, L, L, H, 8'h22);
    @(negedge txclk);
    checkOutput("coll second write full", data_in_udr, H);
    checkOutput("coll second write pulse", wr_collision, L);
    nextCycle();
    applyStimulus(L, L, L, H, L, L, L, 8'h00);
    @(negedge txclk);
    checkOutput("coll pulse", wr_collision, H);
    checkOutput("coll full", data_in_udr, H);
    nextCycle();
    @(negedge txclk);
    checkOutput("coll pulse end", wr_collision, L);
    nextCycle();
    runFrame("coll_22", 8'h22, PAR_EVEN, H, L, -1, 8'h00);

    writeIdle(8'h11);
    runFrame("same_11", 8'h11, PAR_EVEN, H, L, 0, 8'h77);
    runFrame("same_77", 8'h77, PAR_EVEN, H, L, -1, 8'h00);

    writeIdle(8'hC3);
    upm0 = PAR_EVEN;
    applyStimulus(H, L, L, L, H, H, L, 8'h00);
    nextCycle();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(L, H, L, L, L, L, c == 2, 8'hAA);
      nextCycle();
    end
    applyStimulus(L, H, L, L, L, L, L, 8'h00);
    #2;
    rst_n = 1'b0;
    applyStimulus(L, L, L, L, L, L, L, 8'h00);
    #1;
    checkOutput("midreset txd", txd, H);
    checkOutput("midreset udre", udre, H);
    checkOutput("midreset full", data_in_udr, L);
    checkOutput("midreset last", last_bit_sent, L);
    data_transmit = 1'b1;
    #1;
    checkOutput("midreset cnt zero", last_bit_sent, H);
    checkOutput("midreset shift zero", txd, L);
    data_transmit = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(L, L, L, H, L, L, L, 8'h00);
    @(negedge txclk);
    checkOutput("post reset idle txd", txd, H);
    checkOutput("post reset udre", udre, H);
    nextCycle();
    writeIdle(8'h96);
    runFrame("post_rst_96", 8'h96, PAR_EVEN, H, L, -1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_datapath.md
# tx_datapath

Transmit datapath for the USART TX path, sitting directly downstream of the TX control FSM and clocked by the same i_txclk. It holds the UDR transmit buffer and presents its state to the FSM, then loads the transmit shift register, bit counter and parity bit under FSM control. It drives the serial line o_txd, producing LSB-first frames of start bit, DATA_WIDTH data bits, optional parity bit and stop bit(s).

## Interface
- DATA_WIDTH, 8, character size in bits, legal range 5..9.
- CNT_W, $clog2(DATA_WIDTH), bit counter width.

Ports:
- i_txclk  in  1  TX bit clock, one bit time per cycle.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_udr_wr  in  1  UDR write strobe, one cycle, i_txclk domain.
- i_udr_data  in  DATA_WIDTH  character written to UDR.
- i_upm0  in  1  parity mode: 0 even, 1 odd.
- i_start_bit_insert  in  1  FSM: START state.
- i_parity_generate  in  1  FSM: compute parity this cycle.
- i_reg_wr_or_shift  in  1  FSM: 1 load shift register, 0 shift.
- i_rewr_or_count  in  1  FSM: 1 load bit counter, 0 count.
- i_data_transmit  in  1  FSM: SEND_DATA state.
- i_parity_insert  in  1  FSM: parity bit slot.
- i_stop_bit  in  1  FSM: stop or idle, line high.
- o_txd  out  1  serial data line.
- o_data_in_udr  out  1  UDR holds an unsent character (to FSM).
- o_last_bit_sent  out  1  current data cycle carries the last data bit (to FSM).
- o_udre  out  1  UDR empty, equal to ~o_data_in_udr.
- o_wr_collision  out  1  one-cycle pulse: write overwrote an unsent UDR.

## Operation
- UDR buffer: i_udr_wr loads udr_reg and sets full. o_data_in_udr = full.
- Load event = i_reg_wr_or_shift & i_rewr_or_count.
- On a load event:
  - shift_reg <= udr_reg
  - bit_cnt <= DATA_WIDTH-1
  - full <= 0
  - if i_parity_generate: parity_bit <= ^udr_reg ^ i_upm0
- Write and load in the same cycle: shift_reg takes the old udr_reg and udr_reg takes the new data. full stays 1 and no collision is flagged.
- Write while full without a load: udr_reg is overwritten, full stays 1, and o_wr_collision pulses.
- Data cycle (i_data_transmit=1, no load event):
  - shift_reg <= shift_reg >> 1, zero-fill.
  - bit_cnt decrements, saturating at 0.
- o_last_bit_sent = i_data_transmit & (bit_cnt == 0), combinational. It is 0 in START, so a stale counter value is never seen.
- o_txd is a combinational priority mux of registered signals:
  - i_start_bit_insert → 0
  - else i_data_transmit → shift_reg[0]
  - else i_parity_insert → parity_bit
  - else 1
- i_data_transmit has priority over i_parity_insert. Both are high in the last data cycle, and the data bit wins.
- Stop, idle and any undefined control combination give o_txd = 1.

## Timing
- Reset values:
  - udr_reg, shift_reg, bit_cnt, parity_bit = 0; full = 0.
  - o_data_in_udr = 0, o_udre = 1, o_last_bit_sent = 0, o_wr_collision = 0.
  - o_txd = 1, given that the upstream controls also reset to 0.
- Write to o_data_in_udr latency: 1 cycle.
- Frame, one bit per cycle: START (txd 0, load), then DATA_WIDTH data cycles with bit_cnt going DATA_WIDTH-1..0, then optional parity cycle, then stop cycle(s).
- o_last_bit_sent is high exactly in data cycle DATA_WIDTH.
- full clears at the end of the START cycle. A character written during a frame is held, and its START follows the stop/idle cycle back-to-back.
- Reset mid-frame: all state clears asynchronously, o_txd returns high, and the buffered character is lost.
- Data cycles after the counter reaches 0 shift zeros and keep o_last_bit_sent = 1.

## Structure
- Shared package usart_pkg holds:
  - DATA_WIDTH default
  - parity encodings PAR_EVEN=0 and PAR_ODD=1
  - line levels IDLE_LEVEL=1 and START_LEVEL=0
- One sub-module, tx_udr_buffer: udr_reg, full flag and collision detect.
- Shift register, counter, parity and mux stay in tx_datapath.

## Test plan
- Even parity, 0xA5: write 0xA5 with i_upm0=0 and drive the FSM sequence. o_txd must read 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop). o_last_bit_sent is high only in data cycle 8.
- Odd parity, 0x03 (i_upm0=1): parity slot must be 1. With 0x01 and odd parity, the parity slot must be 0.
- Back-to-back: write 0x55, then write 0x0F during its data phase. Second start bit must follow the first frame's stop cycle. o_data_in_udr goes 1→0 at each START, with no collision.
- Collision: two writes, 0x11 then 0x22, with no START in between. o_wr_collision pulses once and the transmitted frame carries 0x22.
- Same-cycle write and load: write 0x77 in the START cycle of the 0x11 frame. The 0x11 frame is sent, o_data_in_udr stays 1, and 0x77 is sent next.
- Reset at data cycle 4: o_txd = 1 immediately, o_udre = 1, bit_cnt = 0, and the next frame after release is correct.
